// File: rtl/pr_sched_pkg.sv
// rtl/pr_sched_pkg.sv - shared types and constants for the demand/prefetch AR scheduler
package pr_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE_D = 2'd1,
    ISSUE_P = 2'd2
  } sched_state_t;

  localparam int AR_ADDR_BITS = 16;
  localparam int AR_LEN_BITS  = 8;
  localparam int AR_ID_BITS   = 8;

  typedef struct packed {
    logic [AR_ADDR_BITS-1:0] addr;
    logic [AR_LEN_BITS-1:0]  len;
    logic [AR_ID_BITS-1:0]   id;
  } ar_req_t;

  localparam logic KIND_DEMAND   = 1'b0;
  localparam logic KIND_PREFETCH = 1'b1;

endpackage

// File: rtl/pr_kind_fifo.sv
// rtl/pr_kind_fifo.sv - 1-bit in-order FIFO recording the kind of every issued burst
module pr_kind_fifo #(
  parameter int LOG_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               push_kind,
  input  logic               pop,
  output logic               head_kind,
  output logic [LOG_DEPTH:0] count,
  output logic               full,
  output logic               empty
);
  localparam int DEPTH = 1 << LOG_DEPTH;

  logic [DEPTH-1:0]   mem_q, mem_d;
  logic [LOG_DEPTH:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_DEPTH:0] rd_ptr_q, rd_ptr_d;
  logic               do_push, do_pop;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign count     = wr_ptr_q - rd_ptr_q;
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[LOG_DEPTH] != rd_ptr_q[LOG_DEPTH]) &&
                     (wr_ptr_q[LOG_DEPTH-1:0] == rd_ptr_q[LOG_DEPTH-1:0]);
  assign head_kind = mem_q[rd_ptr_q[LOG_DEPTH-1:0]];
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[LOG_DEPTH-1:0]] = push_kind;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/pr_ar_scheduler.sv
// rtl/pr_ar_scheduler.sv - arbitrates the DDR AR channel between demand and throttled prefetch reads
module pr_ar_scheduler #(
  parameter int ADDR_BITS         = 16,
  parameter int BURST_LEN_WIDTH   = 8,
  parameter int TID_WIDTH         = 8,
  parameter int LOG_QUEUE_SIZE    = 4,
  parameter int PRFETCH_FRQ_WIDTH = 6,
  parameter int STARVE_CYCLES     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         d_ar_valid,
  output logic                         d_ar_ready,
  input  logic [ADDR_BITS-1:0]         d_ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0]   d_ar_len,
  input  logic [TID_WIDTH-1:0]         d_ar_id,
  input  logic                         p_ar_valid,
  output logic                         p_ar_ready,
  input  logic [ADDR_BITS-1:0]         p_ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0]   p_ar_len,
  input  logic [TID_WIDTH-1:0]         p_ar_id,
  output logic                         m_ar_valid,
  input  logic                         m_ar_ready,
  output logic [ADDR_BITS-1:0]         m_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0]   m_ar_len,
  output logic [TID_WIDTH-1:0]         m_ar_id,
  input  logic                         m_r_valid,
  input  logic                         m_r_ready,
  input  logic                         m_r_last,
  output logic                         r_isPrefetch,
  output logic                         r_kindValid,
  input  logic [LOG_QUEUE_SIZE:0]      crs_prOutstandingLimit,
  input  logic [PRFETCH_FRQ_WIDTH-1:0] crs_prBandwidthThrottle,
  output logic [LOG_QUEUE_SIZE:0]      prOutstanding,
  output logic [1:0]                   errorCode
);
  import pr_sched_pkg::*;

  localparam int                  CNT_W      = LOG_QUEUE_SIZE + 1;
  localparam int                  STARVE_W   = $clog2(STARVE_CYCLES + 1);
  localparam logic [CNT_W-1:0]    FIFO_FULL  = CNT_W'(1 << LOG_QUEUE_SIZE);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_CYCLES);

  sched_state_t               state_q, state_d;
  logic                       m_ar_valid_q, m_ar_valid_d;
  logic [ADDR_BITS-1:0]       m_ar_addr_q, m_ar_addr_d;
  logic [BURST_LEN_WIDTH-1:0] m_ar_len_q, m_ar_len_d;
  logic [TID_WIDTH-1:0]       m_ar_id_q, m_ar_id_d;
  logic [PRFETCH_FRQ_WIDTH-1:0] thr_q, thr_d;
  logic [STARVE_W-1:0]        starve_q, starve_d;
  logic [CNT_W-1:0]           pr_out_q, pr_out_d;
  logic [1:0]                 err_q, err_d;

  logic             fifo_head, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             ar_hs, r_beat, r_last_hs, r_pop;
  logic             grant_ok, p_elig, grant_p, grant_d, pr_inc, pr_dec;

  assign ar_hs     = m_ar_valid_q & m_ar_ready;
  assign r_beat    = m_r_valid & m_r_ready;
  assign r_last_hs = r_beat & m_r_last;
  assign r_pop     = r_last_hs & ~fifo_empty;

  // Only IDLE grants, so no burst is pending when the FIFO occupancy is checked.
  assign grant_ok = ~rst & en & (state_q == IDLE) & (fifo_count != FIFO_FULL);
  assign p_elig   = p_ar_valid & (pr_out_q < crs_prOutstandingLimit) & (thr_q == '0);
  assign grant_p  = grant_ok & p_elig & (~d_ar_valid | (starve_q >= STARVE_MAX));
  assign grant_d  = grant_ok & d_ar_valid & ~grant_p;

  assign pr_inc = ar_hs & (state_q == ISSUE_P);
  assign pr_dec = r_pop & fifo_head;

  always_comb begin
    state_d      = state_q;
    m_ar_valid_d = m_ar_valid_q;
    m_ar_addr_d  = m_ar_addr_q;
    m_ar_len_d   = m_ar_len_q;
    m_ar_id_d    = m_ar_id_q;
    case (state_q)
      IDLE: begin
        if (grant_p) begin
          state_d      = ISSUE_P;
          m_ar_valid_d = 1'b1;
          m_ar_addr_d  = p_ar_addr;
          m_ar_len_d   = p_ar_len;
          m_ar_id_d    = p_ar_id;
        end else if (grant_d) begin
          state_d      = ISSUE_D;
          m_ar_valid_d = 1'b1;
          m_ar_addr_d  = d_ar_addr;
          m_ar_len_d   = d_ar_len;
          m_ar_id_d    = d_ar_id;
        end
      end
      ISSUE_D, ISSUE_P: begin
        if (m_ar_ready) begin
          state_d      = IDLE;
          m_ar_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    thr_d = thr_q;
    if (grant_p) begin
      thr_d = crs_prBandwidthThrottle;
    end else if (thr_q != '0) begin
      thr_d = thr_q - 1'b1;
    end

    starve_d = starve_q;
    if (grant_p) begin
      starve_d = '0;
    end else if (p_elig && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 1'b1;
    end

    pr_out_d = pr_out_q;
    if (pr_inc && !pr_dec) begin
      pr_out_d = pr_out_q + 1'b1;
    end else if (pr_dec && !pr_inc) begin
      pr_out_d = pr_out_q - 1'b1;
    end

    err_d = err_q | {ar_hs & fifo_full & ~r_pop, r_beat & fifo_empty};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      m_ar_valid_q <= 1'b0;
      m_ar_addr_q  <= '0;
      m_ar_len_q   <= '0;
      m_ar_id_q    <= '0;
      thr_q        <= '0;
      starve_q     <= '0;
      pr_out_q     <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      m_ar_valid_q <= m_ar_valid_d;
      m_ar_addr_q  <= m_ar_addr_d;
      m_ar_len_q   <= m_ar_len_d;
      m_ar_id_q    <= m_ar_id_d;
      thr_q        <= thr_d;
      starve_q     <= starve_d;
      pr_out_q     <= pr_out_d;
      err_q        <= err_d;
    end
  end

  pr_kind_fifo #(
    .LOG_DEPTH(LOG_QUEUE_SIZE)
  ) u_kind_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ar_hs),
    .push_kind ((state_q == ISSUE_P) ? KIND_PREFETCH : KIND_DEMAND),
    .pop       (r_last_hs),
    .head_kind (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign d_ar_ready    = grant_d;
  assign p_ar_ready    = grant_p;
  assign m_ar_valid    = m_ar_valid_q;
  assign m_ar_addr     = m_ar_addr_q;
  assign m_ar_len      = m_ar_len_q;
  assign m_ar_id       = m_ar_id_q;
  assign r_kindValid   = ~fifo_empty;
  assign r_isPrefetch  = ~fifo_empty & fifo_head;
  assign prOutstanding = pr_out_q;
  assign errorCode     = err_q;

endmodule

// File: tb/tb_pr_ar_scheduler.sv
// tb/tb_pr_ar_scheduler.sv - randomized scoreboard bench for pr_ar_scheduler
module tb_pr_ar_scheduler;
  import pr_sched_pkg::*;

  localparam int AW = 16, LW = 8, IW = 8, LQ = 4, FW = 6, STARVE = 16, DEPTH = 16;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic d_ar_valid = 1'b0, p_ar_valid = 1'b0, m_ar_ready = 1'b0;
  logic d_ar_ready, p_ar_ready, m_ar_valid;
  logic [AW-1:0] d_ar_addr = '0, p_ar_addr = '0, m_ar_addr;
  logic [LW-1:0] d_ar_len = '0, p_ar_len = '0, m_ar_len;
  logic [IW-1:0] d_ar_id = '0, p_ar_id = '0, m_ar_id;
  logic m_r_valid = 1'b0, m_r_ready = 1'b0, m_r_last = 1'b0;
  logic r_isPrefetch, r_kindValid;
  logic [LQ:0] crs_prOutstandingLimit = '0, prOutstanding;
  logic [FW-1:0] crs_prBandwidthThrottle = '0;
  logic [1:0] errorCode;

  always #5 clk = ~clk;

  pr_ar_scheduler #(
    .ADDR_BITS(AW), .BURST_LEN_WIDTH(LW), .TID_WIDTH(IW),
    .LOG_QUEUE_SIZE(LQ), .PRFETCH_FRQ_WIDTH(FW), .STARVE_CYCLES(STARVE)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .d_ar_valid(d_ar_valid), .d_ar_ready(d_ar_ready),
    .d_ar_addr(d_ar_addr), .d_ar_len(d_ar_len), .d_ar_id(d_ar_id),
    .p_ar_valid(p_ar_valid), .p_ar_ready(p_ar_ready),
    .p_ar_addr(p_ar_addr), .p_ar_len(p_ar_len), .p_ar_id(p_ar_id),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_last(m_r_last),
    .r_isPrefetch(r_isPrefetch), .r_kindValid(r_kindValid),
    .crs_prOutstandingLimit(crs_prOutstandingLimit),
    .crs_prBandwidthThrottle(crs_prBandwidthThrottle),
    .prOutstanding(prOutstanding), .errorCode(errorCode)
  );

  typedef struct { ar_req_t req; bit kind; } exp_ar_t;
  typedef struct { bit kind; int len; } burst_t;

  int n_cmp = 0, n_bad = 0;
  exp_ar_t exp_ar_q[$];

  bit chk = 1'b0;
  bit e_d_rdy, e_p_rdy, e_m_valid, e_kvalid, e_rpf;
  int e_pr_out;
  bit [1:0] e_err;

  // Reference model: bursts in flight in issue order, plus arbitration history.
  burst_t infl[$];
  bit busy, pend_kind, g_d, g_p, p_el, force_stray;
  int pend_len, beat_idx, cyc, last_pg, last_thr, starve;
  bit [1:0] m_err;
  int d_pct, p_pct, mr_pct, rv_pct, en_pct, lim, thr;

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk) begin
        cmp("d_ar_ready", int'(d_ar_ready), int'(e_d_rdy));
        cmp("p_ar_ready", int'(p_ar_ready), int'(e_p_rdy));
        cmp("m_ar_valid", int'(m_ar_valid), int'(e_m_valid));
        cmp("r_kindValid", int'(r_kindValid), int'(e_kvalid));
        cmp("prOutstanding", int'(prOutstanding), e_pr_out);
        cmp("errorCode", int'(errorCode), int'(e_err));
        if (e_kvalid) cmp("r_isPrefetch", int'(r_isPrefetch), int'(e_rpf));
        if (m_ar_valid) begin
          if (exp_ar_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL m_ar_unexpected: got addr %0h expected none at %0t", m_ar_addr, $time);
          end else begin
            cmp("m_ar_addr", int'(m_ar_addr), int'(exp_ar_q[0].req.addr));
            cmp("m_ar_len", int'(m_ar_len), int'(exp_ar_q[0].req.len));
            cmp("m_ar_id", int'(m_ar_id), int'(exp_ar_q[0].req.id));
            if (m_ar_ready) void'(exp_ar_q.pop_front());
          end
        end
      end
    end
  end

  function automatic int pr_cnt();
    int n = 0;
    foreach (infl[i]) if (infl[i].kind) n++;
    return n;
  endfunction

  function automatic bit roll(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  task automatic knobs(input int d, input int p, input int mr, input int rv,
                       input int e, input int l, input int t);
    d_pct = d; p_pct = p; mr_pct = mr; rv_pct = rv; en_pct = e; lim = l; thr = t;
  endtask

  task automatic step(input bit rst_next);
    bit rbeat, can;
    burst_t b;
    exp_ar_t ea;
    @(posedge clk);
    #1;
    rbeat = m_r_valid && m_r_ready;
    if (rst) begin
      busy = 0; infl.delete(); beat_idx = 0; starve = 0;
      last_pg = -1000; last_thr = 0; m_err = 0; exp_ar_q.delete();
    end else begin
      if (rbeat) begin
        if (infl.size() == 0) m_err[0] = 1'b1;
        else if (m_r_last) begin void'(infl.pop_front()); beat_idx = 0; end
        else beat_idx++;
      end
      if (busy && m_ar_ready) begin
        b.kind = pend_kind; b.len = pend_len;
        infl.push_back(b);
        busy = 0;
      end
      if (g_p) begin
        busy = 1; pend_kind = 1; pend_len = int'(p_ar_len);
        starve = 0; last_pg = cyc; last_thr = int'(crs_prBandwidthThrottle);
        p_ar_valid = 1'b0;
      end else if (p_el && starve < STARVE) begin
        starve++;
      end
      if (g_d) begin
        busy = 1; pend_kind = 0; pend_len = int'(d_ar_len);
        d_ar_valid = 1'b0;
      end
    end
    cyc++;

    rst = rst_next;
    en = roll(en_pct);
    if (!d_ar_valid && roll(d_pct)) begin
      d_ar_valid = 1'b1; d_ar_addr = AW'($urandom);
      d_ar_len = LW'($urandom_range(7)); d_ar_id = IW'($urandom);
    end
    if (!p_ar_valid && roll(p_pct)) begin
      p_ar_valid = 1'b1; p_ar_addr = AW'($urandom);
      p_ar_len = LW'($urandom_range(7)); p_ar_id = IW'($urandom);
    end
    m_ar_ready = roll(mr_pct);
    crs_prOutstandingLimit = (LQ+1)'(lim);
    crs_prBandwidthThrottle = FW'(thr);
    if (force_stray) begin
      m_r_valid = 1'b1; m_r_ready = 1'b1; m_r_last = 1'b1;
    end else if (infl.size() > 0 && roll(rv_pct)) begin
      m_r_valid = 1'b1; m_r_ready = roll(80); m_r_last = (beat_idx == infl[0].len);
    end else begin
      m_r_valid = 1'b0; m_r_ready = roll(50); m_r_last = 1'b0;
    end

    p_el = p_ar_valid && (pr_cnt() < lim) && (cyc - last_pg > last_thr);
    can = !rst && en && !busy && (infl.size() < DEPTH);
    g_p = can && p_el && (!d_ar_valid || starve >= STARVE);
    g_d = can && d_ar_valid && !g_p;
    if (g_p || g_d) begin
      ea.req.addr = g_p ? p_ar_addr : d_ar_addr;
      ea.req.len  = g_p ? p_ar_len  : d_ar_len;
      ea.req.id   = g_p ? p_ar_id   : d_ar_id;
      ea.kind     = g_p;
      exp_ar_q.push_back(ea);
    end
    e_d_rdy = g_d; e_p_rdy = g_p; e_m_valid = busy;
    e_kvalid = infl.size() > 0;
    e_rpf = e_kvalid ? infl[0].kind : 1'b0;
    e_pr_out = pr_cnt();
    e_err = m_err;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  initial begin
    cyc = 0; force_stray = 0; g_d = 0; g_p = 0; p_el = 0; busy = 0;
    knobs(0, 0, 100, 0, 0, 0, 0);
    step(1'b1);
    step(1'b0);
    chk = 1'b1;
    run(2);
    knobs(50, 50, 70, 60, 90, 4, 3);    run(1200);
    knobs(100, 100, 100, 70, 100, 8, 0); run(300);
    knobs(0, 100, 100, 0, 100, 3, 0);   run(40);
    knobs(0, 100, 100, 60, 100, 3, 0);  run(60);
    knobs(100, 0, 100, 0, 100, 4, 2);   run(60);
    knobs(100, 0, 100, 80, 100, 4, 2);  run(100);
    knobs(50, 50, 20, 60, 50, 5, 5);    run(400);
    knobs(40, 80, 70, 60, 90, 0, 1);    run(200);
    knobs(100, 100, 100, 0, 100, 4, 0); run(20);
    step(1'b1);
    force_stray = 1;
    step(1'b0);
    force_stray = 0;
    knobs(50, 60, 70, 60, 90, 6, 2);    run(600);
    knobs(0, 0, 100, 100, 100, 4, 0);   run(150);
    cmp("exp_ar_drained", exp_ar_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
